// File: rtl/output_port_reader.sv
// output_port_reader
//   Drain side of the switch's per-input queues. Keeps an occupancy count per
//   queue by snooping its write strobe and the read pulses issued here. It
//   picks a non-empty queue round-robin at packet granularity, pulses that
//   queue's read enable, captures the returned word and presents it on a
//   single valid/ready output port. Bit DATA_W of a queue word marks EOP.
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   q_wr_en    snooped write strobes, one per queue
//   q_rd_data  queue read data, queue i at [i*(DATA_W+1) +: DATA_W+1]
//   q_rd_en    one-hot read pulse to the granted queue
//   out_data   payload word
//   out_eop    word is last of its packet
//   out_src    index of the source queue
//   out_valid  out_data/out_eop/out_src valid
//   out_ready  downstream accepts the word this cycle
//   overflow   sticky: a write was seen on a full queue
module output_port_reader #(
  parameter int NUM_Q  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_Q-1:0]              q_wr_en,
  input  logic [NUM_Q*(DATA_W+1)-1:0]   q_rd_data,
  output logic [NUM_Q-1:0]              q_rd_en,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_eop,
  output logic [1:0]                    out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow
);

  localparam int IDX_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int WORD_W = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

  state_t             state;
  logic [IDX_W-1:0]   cur;
  logic [IDX_W-1:0]   last_grant;
  logic               lock;
  logic [CNT_W-1:0]   cnt [NUM_Q];

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  rd_word;

  // Occupancy tracking. A write and a read in the same cycle cancel out; a
  // write to a full queue with no read leaves the count at DEPTH and flags
  // overflow until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_Q; i++) cnt[i] <= '0;
      overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_Q; i++) begin
        if (q_wr_en[i] && !q_rd_en[i]) begin
          if (cnt[i] == CNT_W'(DEPTH)) overflow <= 1'b1;
          else                         cnt[i]   <= cnt[i] + 1'b1;
        end else if (!q_wr_en[i] && q_rd_en[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Round-robin search: first non-empty queue starting just after last_grant.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_Q; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % NUM_Q);
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (cur == IDX_W'(i)) rd_word = q_rd_data[i*WORD_W +: WORD_W];
    end
  end

  // One word in flight: IDLE issues the read, READ lets the queue register
  // the word, CAPT samples it, SEND holds it until accepted. The grant lock
  // is released only when an EOP word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      lock       <= 1'b0;
      last_grant <= IDX_W'(NUM_Q - 1);
      q_rd_en    <= '0;
      out_data   <= '0;
      out_eop    <= 1'b0;
      out_src    <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock) begin
            if (cnt[cur] != '0) begin
              q_rd_en <= NUM_Q'(1) << cur;
              state   <= READ;
            end
          end else if (found) begin
            cur     <= pick;
            q_rd_en <= NUM_Q'(1) << pick;
            lock    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          q_rd_en <= '0;
          state   <= CAPT;
        end
        CAPT: begin
          out_data  <= rd_word[DATA_W-1:0];
          out_eop   <= rd_word[DATA_W];
          out_src   <= 2'(cur);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_eop) begin
              lock       <= 1'b0;
              last_grant <= cur;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_reader.sv
// tb_output_port_reader
//   Directed bench for output_port_reader. Each queue is modelled as a simple
//   FIFO whose read data register updates on the DUT's q_rd_en; accepted
//   output words are logged and compared against hand-computed values.
module tb_output_port_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   q_wr_en;
  logic [131:0] q_rd_data;
  logic [3:0]   q_rd_en;
  logic [31:0]  out_data;
  logic         out_eop;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  output_port_reader #(.NUM_Q(4), .DATA_W(32), .DEPTH(128), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .q_wr_en(q_wr_en), .q_rd_data(q_rd_data),
    .q_rd_en(q_rd_en), .out_data(out_data), .out_eop(out_eop),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Queue models
  logic [32:0] mem [4][512];
  int          wp [4];
  int          rp [4];
  logic [32:0] rd_reg [4];
  logic [32:0] wdata [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wp[i] <= 0; rp[i] <= 0; rd_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (q_wr_en[i]) begin
          mem[i][wp[i][8:0]] <= wdata[i];
          wp[i] <= (wp[i] + 1) % 512;
        end
        if (q_rd_en[i]) begin
          rd_reg[i] <= mem[i][rp[i][8:0]];
          rp[i] <= (rp[i] + 1) % 512;
        end
      end
    end
  end

  assign q_rd_data = {rd_reg[3], rd_reg[2], rd_reg[1], rd_reg[0]};

  // Output log and read-pulse counters
  logic [31:0] log_data [64];
  logic        log_eop  [64];
  logic [1:0]  log_src  [64];
  int          n_acc;
  int          rd_cnt [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_acc <= 0;
      for (int i = 0; i < 4; i++) rd_cnt[i] <= 0;
    end else begin
      if (out_valid && out_ready && n_acc < 64) begin
        log_data[n_acc] <= out_data;
        log_eop[n_acc]  <= out_eop;
        log_src[n_acc]  <= out_src;
        n_acc <= n_acc + 1;
      end
      for (int i = 0; i < 4; i++) if (q_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    q_wr_en = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds q_wr_en[q] for n consecutive edges with data base, base+1, ...
  task automatic wr_burst(input int q, input int n, input logic [32:0] base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      q_wr_en[q] = 1'b1;
      wdata[q]   = base + 33'(k);
    end
    @(negedge clk);
    q_wr_en = '0;
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int c = 0; c < 300 && n_acc < n; c++) @(negedge clk);
    check(tag, 64'(n_acc), 64'(n));
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 50 && !out_valid; c++) @(negedge clk);
    check(tag, 64'(out_valid), 64'd1);
  endtask

  logic        stable;
  logic [31:0] held;

  initial begin
    rst = 1'b1;
    q_wr_en = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wdata[i] = '0;

    // 1 Reset with write strobes toggling
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      q_wr_en = (c % 2 == 0) ? 4'hF : 4'h0;
    end
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_rd_en", 64'(q_rd_en), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_cnt", 64'(dut.cnt[0]) + 64'(dut.cnt[1]) + 64'(dut.cnt[2]) + 64'(dut.cnt[3]), 64'd0);
    q_wr_en = '0;
    rst = 1'b0;

    // 2 Single word with latency
    wr_burst(2, 1, 33'h1_DEADBEEF);
    @(negedge clk);
    check("sw_rd_en", 64'(q_rd_en), 64'h4);
    @(negedge clk);
    check("sw_rd_off", 64'(q_rd_en), 64'h0);
    check("sw_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("sw_valid", 64'(out_valid), 64'd1);
    check("sw_data", 64'(out_data), 64'hDEADBEEF);
    check("sw_eop", 64'(out_eop), 64'd1);
    check("sw_src", 64'(out_src), 64'd2);
    check("sw_cnt2", 64'(dut.cnt[2]), 64'd0);
    check("sw_rdcnt", 64'(rd_cnt[2]), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("sw_accept", 64'(out_valid), 64'd0);

    // 3 Round-robin
    reset_dut();
    @(negedge clk);
    wdata[0] = 33'h1_000000A0;
    wdata[1] = 33'h1_000000A1;
    wdata[3] = 33'h1_000000A3;
    q_wr_en = 4'b1011;
    @(negedge clk);
    q_wr_en = '0;
    wait_acc(3, "rr_n3");
    check("rr_src0", 64'(log_src[0]), 64'd0);
    check("rr_src1", 64'(log_src[1]), 64'd1);
    check("rr_src2", 64'(log_src[2]), 64'd3);
    check("rr_dat2", 64'(log_data[2]), 64'hA3);
    wdata[0] = 33'h1_000000B0;
    wdata[3] = 33'h1_000000B3;
    q_wr_en = 4'b1001;
    @(negedge clk);
    q_wr_en = '0;
    wait_acc(5, "rr_n5");
    check("rr_src3", 64'(log_src[3]), 64'd0);
    check("rr_dat3", 64'(log_data[3]), 64'hB0);
    check("rr_src4", 64'(log_src[4]), 64'd3);

    // 4 Packet lock
    reset_dut();
    wr_burst(1, 2, 33'h0_00000011);
    wr_burst(0, 4, 33'h1_00000020);
    repeat (20) @(negedge clk);
    check("lk_stall_n", 64'(n_acc), 64'd2);
    check("lk_src0", 64'(log_src[0]), 64'd1);
    check("lk_dat1", 64'(log_data[1]), 64'h12);
    check("lk_eop1", 64'(log_eop[1]), 64'd0);
    check("lk_no_q0", 64'(rd_cnt[0]), 64'd0);
    wr_burst(1, 1, 33'h1_00000013);
    wait_acc(7, "lk_n7");
    check("lk_src2", 64'(log_src[2]), 64'd1);
    check("lk_dat2", 64'(log_data[2]), 64'h13);
    check("lk_eop2", 64'(log_eop[2]), 64'd1);
    check("lk_src3", 64'(log_src[3]), 64'd0);
    check("lk_dat3", 64'(log_data[3]), 64'h20);
    check("lk_dat6", 64'(log_data[6]), 64'h23);

    // 5 Backpressure
    out_ready = 1'b0;
    reset_dut();
    wr_burst(2, 2, 33'h1_00005500);
    wait_valid("bp_valid");
    held = out_data;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== held || out_valid !== 1'b1 || out_src !== 2'd2 || q_rd_en !== 4'h0)
        stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_data", 64'(held), 64'h5500);
    check("bp_rd_once", 64'(rd_cnt[2]), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_v", 64'(out_valid), 64'd0);
    check("bp_accept_n", 64'(n_acc), 64'd1);
    wait_acc(2, "bp_n2");
    check("bp_next", 64'(log_data[1]), 64'h5501);

    // 6 Boundaries
    out_ready = 1'b0;
    reset_dut();
    wr_burst(0, 1, 33'h1_00000100);
    wait_valid("bd_first");
    check("bd_cnt0", 64'(dut.cnt[0]), 64'd0);
    wr_burst(0, 128, 33'h1_00001000);
    check("bd_cnt128", 64'(dut.cnt[0]), 64'd128);
    check("bd_ovf0", 64'(overflow), 64'd0);
    wr_burst(0, 1, 33'h1_00002000);
    check("bd_cnt_sat", 64'(dut.cnt[0]), 64'd128);
    check("bd_ovf1", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bd_acc", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("bd_rd", 64'(q_rd_en), 64'h1);
    q_wr_en[0] = 1'b1;
    wdata[0] = 33'h1_00003000;
    @(negedge clk);
    q_wr_en = '0;
    check("bd_wr_rd_cnt", 64'(dut.cnt[0]), 64'd128);
    check("bd_wr_rd_ovf", 64'(overflow), 64'd1);
    @(negedge clk);
    check("bd_send", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("bd_rst_valid", 64'(out_valid), 64'd0);
    check("bd_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
